// File: rtl/gerenciador_escritas.sv
// gerenciador_escritas: round-robin arbiter issuing one wide memory write.
// Define GERENCIADOR_ESCRITAS_MASK_EN to add per-port write masks.
module gerenciador_escritas #(
   parameter int NUM_WRITE_PORTS  = 8,
   parameter int NUM_SOLICITACOES = 8,
   parameter int DATA_WIDH        = 32,
   parameter int ADDR_WIDTH       = 8
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic [NUM_SOLICITACOES-1:0]                         lvv_write_en_in,
   input  logic [ADDR_WIDTH*NUM_WRITE_PORTS*NUM_SOLICITACOES-1:0] lvv_write_addr_in,
   input  logic [DATA_WIDH*NUM_WRITE_PORTS*NUM_SOLICITACOES-1:0]  lvv_write_data_in,
`ifdef GERENCIADOR_ESCRITAS_MASK_EN
   input  logic [NUM_WRITE_PORTS*NUM_SOLICITACOES-1:0]         lvv_write_mask_in,
`endif
   output logic [NUM_SOLICITACOES-1:0]                         ready_out,
   output logic                                                busy_out,
   output logic [NUM_WRITE_PORTS-1:0]                          write_en_out,
   output logic [ADDR_WIDTH*NUM_WRITE_PORTS-1:0]               write_addr_out,
   output logic [DATA_WIDH*NUM_WRITE_PORTS-1:0]                write_data_out
);

   localparam int IW = (NUM_SOLICITACOES > 1) ? $clog2(NUM_SOLICITACOES) : 1;
   localparam int AS = ADDR_WIDTH * NUM_WRITE_PORTS;
   localparam int DS = DATA_WIDH * NUM_WRITE_PORTS;

   localparam logic [0:0] OCIOSO  = 1'b0;
   localparam logic [0:0] ESCREVE = 1'b1;

   logic [0:0]                 estado;
   logic [IW-1:0]              ultimo;
   logic [IW-1:0]              vencedor;
   logic [IW-1:0]              idx;
   logic                       tem_pedido;
   logic [NUM_WRITE_PORTS-1:0] mascara;

   // First set request bit after the previous winner, wrapping around
   always_comb begin
      vencedor   = ultimo;
      idx        = '0;
      tem_pedido = 1'b0;
      for (int i = 1; i <= NUM_SOLICITACOES; i++) begin
         idx = IW'((int'(ultimo) + i) % NUM_SOLICITACOES);
         if (!tem_pedido && lvv_write_en_in[idx]) begin
            vencedor   = idx;
            tem_pedido = 1'b1;
         end
      end
   end

   always_comb begin
`ifdef GERENCIADOR_ESCRITAS_MASK_EN
      mascara = lvv_write_mask_in[vencedor*NUM_WRITE_PORTS +: NUM_WRITE_PORTS];
`else
      mascara = '1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado         <= OCIOSO;
         ultimo         <= IW'(NUM_SOLICITACOES - 1);
         ready_out      <= '0;
         busy_out       <= 1'b0;
         write_en_out   <= '0;
         write_addr_out <= '0;
         write_data_out <= '0;
      end else if (estado == OCIOSO && tem_pedido) begin
         estado         <= ESCREVE;
         ultimo         <= vencedor;
         ready_out      <= NUM_SOLICITACOES'(1) << vencedor;
         busy_out       <= 1'b1;
         write_en_out   <= mascara;
         write_addr_out <= lvv_write_addr_in[vencedor*AS +: AS];
         write_data_out <= lvv_write_data_in[vencedor*DS +: DS];
      end else begin
         // ESCREVE is a single cycle; addr/data keep their last values
         estado       <= OCIOSO;
         ready_out    <= '0;
         busy_out     <= 1'b0;
         write_en_out <= '0;
      end
   end

endmodule

// File: tb/tb_gerenciador_escritas.sv
// Bench for gerenciador_escritas: vector table plus scoreboard queue.
// Mask checks compile in with GERENCIADOR_ESCRITAS_MASK_EN.
module tb_gerenciador_escritas;

   localparam int NP = 8;
   localparam int NS = 8;
   localparam int DW = 32;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst;
   logic [NS-1:0]         en;
   logic [AW*NP*NS-1:0]   addr_in;
   logic [DW*NP*NS-1:0]   data_in;
`ifdef GERENCIADOR_ESCRITAS_MASK_EN
   logic [NP*NS-1:0]      mask_in;
`endif
   logic [NS-1:0]         ready;
   logic                  busy;
   logic [NP-1:0]         wen;
   logic [AW*NP-1:0]      waddr;
   logic [DW*NP-1:0]      wdata;

   gerenciador_escritas #(
      .NUM_WRITE_PORTS(NP),
      .NUM_SOLICITACOES(NS),
      .DATA_WIDH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .lvv_write_en_in(en),
      .lvv_write_addr_in(addr_in),
      .lvv_write_data_in(data_in),
`ifdef GERENCIADOR_ESCRITAS_MASK_EN
      .lvv_write_mask_in(mask_in),
`endif
      .ready_out(ready),
      .busy_out(busy),
      .write_en_out(wen),
      .write_addr_out(waddr),
      .write_data_out(wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NS-1:0] ready;
      logic          busy;
      logic [NP-1:0] wen;
      int            win;
   } exp_t;

   typedef struct {
      logic [NS-1:0] en;
      int            win;
   } vec_t;

   exp_t sb[$];
   vec_t tab[12];
   int checks = 0;
   int errors = 0;
   int last_win = -1;

   function automatic logic [AW*NP-1:0] addr_of(int k);
      logic [AW*NP-1:0] r;
      for (int p = 0; p < NP; p++) r[p*AW +: AW] = AW'(k*16 + p);
      return r;
   endfunction

   function automatic logic [DW*NP-1:0] data_of(int k);
      logic [DW*NP-1:0] r;
      for (int p = 0; p < NP; p++) r[p*DW +: DW] = 32'hA500_0000 | DW'(k << 8) | DW'(p);
      return r;
   endfunction

   task automatic cmp(string nm, logic [DW*NP-1:0] act, logic [DW*NP-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_grant(int k, logic [NP-1:0] m = '1);
      exp_t e;
      e.ready = NS'(1) << k;
      e.busy  = 1'b1;
      e.wen   = m;
      e.win   = k;
      sb.push_back(e);
   endtask

   task automatic push_idle();
      exp_t e;
      e.ready = '0;
      e.busy  = 1'b0;
      e.wen   = '0;
      e.win   = -1;
      sb.push_back(e);
   endtask

   task automatic check_sb(string nm);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", nm);
         return;
      end
      e = sb.pop_front();
      cmp({nm, ".ready"}, (DW*NP)'(ready), (DW*NP)'(e.ready));
      cmp({nm, ".busy"}, (DW*NP)'(busy), (DW*NP)'(e.busy));
      cmp({nm, ".wen"}, (DW*NP)'(wen), (DW*NP)'(e.wen));
      if (e.win >= 0) last_win = e.win;
      if (last_win >= 0) begin
         cmp({nm, ".addr"}, (DW*NP)'(waddr), (DW*NP)'(addr_of(last_win)));
         cmp({nm, ".data"}, wdata, data_of(last_win));
      end else begin
         cmp({nm, ".addr"}, (DW*NP)'(waddr), '0);
         cmp({nm, ".data"}, wdata, '0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = '0;
      last_win = -1;
      push_idle();
      tick();
      check_sb("reset");
      rst = 1'b0;
   endtask

   initial begin
      // Expected winners worked out by hand from ultimo=7 after reset
      tab[0]  = '{8'h01, 0};
      tab[1]  = '{8'h81, 7};
      tab[2]  = '{8'h81, 0};
      tab[3]  = '{8'h00, -1};
      tab[4]  = '{8'hFF, 1};
      tab[5]  = '{8'h02, 1};
      tab[6]  = '{8'h06, 2};
      tab[7]  = '{8'h06, 1};
      tab[8]  = '{8'hF0, 4};
      tab[9]  = '{8'h10, 4};
      tab[10] = '{8'h08, 3};
      tab[11] = '{8'h80, 7};

      for (int k = 0; k < NS; k++) begin
         addr_in[k*AW*NP +: AW*NP] = addr_of(k);
         data_in[k*DW*NP +: DW*NP] = data_of(k);
      end
`ifdef GERENCIADOR_ESCRITAS_MASK_EN
      mask_in = '1;
`endif
      rst = 1'b1;
      en  = '0;
      tick();

      do_reset();
      for (int i = 0; i < 12; i++) begin
         en = tab[i].en;
         if (tab[i].win >= 0) push_grant(tab[i].win);
         else push_idle();
         tick();
         check_sb($sformatf("vec%0d", i));
         en = '0;
         push_idle();
         tick();
         check_sb($sformatf("vec%0d_after", i));
      end

      // 0x81 held, each requester drops after its ready
      do_reset();
      en = 8'h81;
      push_grant(0);
      tick();
      check_sb("rr81_g0");
      en = 8'h80;
      push_idle();
      tick();
      check_sb("rr81_gap");
      push_grant(7);
      tick();
      check_sb("rr81_g7");
      en = '0;
      push_idle();
      tick();
      check_sb("rr81_end");

      // All requesters retrying: 0..7,0 with one grant per two cycles
      do_reset();
      en = '1;
      for (int i = 0; i < 18; i++) begin
         if (i % 2 == 0) push_grant((i / 2) % NS);
         else push_idle();
         tick();
         check_sb($sformatf("all_%0d", i));
      end
      en = '0;
      tick();

      // Reset during ESCREVE: ultimo back to 7 so 3 beats 7 again
      do_reset();
      en = 8'h88;
      push_grant(3);
      tick();
      check_sb("rstw_g3");
      rst = 1'b1;
      last_win = -1;
      push_idle();
      tick();
      check_sb("rstw_abort");
      rst = 1'b0;
      push_grant(3);
      tick();
      check_sb("rstw_regrant");
      en = '0;
      push_idle();
      tick();
      check_sb("rstw_end");

`ifdef GERENCIADOR_ESCRITAS_MASK_EN
      do_reset();
      mask_in[2*NP +: NP] = 8'h05;
      en = 8'h04;
      push_grant(2, 8'h05);
      tick();
      check_sb("mask05");
      en = '0;
      push_idle();
      tick();
      check_sb("mask05_end");
      mask_in[2*NP +: NP] = 8'h00;
      en = 8'h04;
      push_grant(2, 8'h00);
      tick();
      check_sb("mask00");
      en = '0;
      push_idle();
      tick();
      check_sb("mask00_end");
      mask_in = '1;
`endif

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gerenciador_escritas.md
GERENCIADOR_ESCRITAS -- requirements
Module: gerenciador_escritas

Interface
REQ-001 SHALL have parameter NUM_WRITE_PORTS, default 8, number of memory write ports driven in parallel.
REQ-002 SHALL have parameter NUM_SOLICITACOES, default 8, number of write requesters.
REQ-003 SHALL have parameter DATA_WIDH, default 32, data width per write port.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, address width per write port.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic samples on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port lvv_write_en_in, input, NUM_SOLICITACOES, per-requester write request level.
REQ-008 SHALL have port lvv_write_addr_in, input, ADDR_WIDTH*NUM_WRITE_PORTS*NUM_SOLICITACOES, requester k's slice is [ADDR_WIDTH*NUM_WRITE_PORTS*(k+1)-1 : ADDR_WIDTH*NUM_WRITE_PORTS*k].
REQ-009 SHALL have port lvv_write_data_in, input, DATA_WIDH*NUM_WRITE_PORTS*NUM_SOLICITACOES, packed the same way as REQ-008.
REQ-010 SHALL have port ready_out, output, NUM_SOLICITACOES, one-hot write-done pulse.
REQ-011 SHALL have port busy_out, output, 1, high while a write is being issued.
REQ-012 SHALL have port write_en_out, output, NUM_WRITE_PORTS, per-port memory write enable.
REQ-013 SHALL have port write_addr_out, output, ADDR_WIDTH*NUM_WRITE_PORTS, memory write addresses.
REQ-014 SHALL have port write_data_out, output, DATA_WIDH*NUM_WRITE_PORTS, memory write data.

Function
REQ-015 SHALL implement a two-state FSM: OCIOSO and ESCREVE.
REQ-016 In OCIOSO, SHALL pick a winner by round-robin when any lvv_write_en_in bit is high, then go to ESCREVE; with no request it SHALL stay in OCIOSO.
REQ-017 Round-robin SHALL search from index (ultimo+1) mod NUM_SOLICITACOES upward with wrap-around, grant the first set bit, and load ultimo with the winner index.
REQ-018 On entering ESCREVE, SHALL register the winner's address and data slices to write_addr_out and write_data_out, set write_en_out to all ones, set ready_out[winner]=1 and set busy_out=1.
REQ-019 ESCREVE SHALL last exactly one cycle and always return to OCIOSO; it SHALL NOT arbitrate.
REQ-020 Latency SHALL be: request sampled in cycle t, memory write and ready pulse in cycle t+1; maximum throughput SHALL be one write per 2 cycles.
REQ-021 Each requester SHALL hold lvv_write_en_in, addr and data stable until it sees its ready_out pulse, and SHALL drop en on the next edge; a request still high in the next OCIOSO cycle counts as a new write.
REQ-022 ready_out SHALL be a single-cycle pulse with at most one bit high.
REQ-023 In OCIOSO, write_en_out, ready_out and busy_out SHALL be 0, and write_addr_out/write_data_out SHALL hold their last values.
REQ-024 A request deasserted before it is granted SHALL be dropped without any write.

Reset
REQ-025 While rst=1 at an edge: FSM SHALL go to OCIOSO, ultimo SHALL be NUM_SOLICITACOES-1 so requester 0 has first priority, and every output SHALL be all zeros.
REQ-026 Reset asserted during ESCREVE SHALL abort that cycle's outputs on the next edge; the requester's pending handshake is lost and it SHALL keep en high to retry.

Configuration
REQ-027 With macro GERENCIADOR_ESCRITAS_MASK_EN defined, input lvv_write_mask_in (NUM_WRITE_PORTS*NUM_SOLICITACOES, packed per requester) SHALL exist, and in ESCREVE write_en_out SHALL equal the winner's mask slice; a winner with an all-zero mask SHALL still receive its ready pulse.
REQ-028 Without GERENCIADOR_ESCRITAS_MASK_EN, the lvv_write_mask_in port SHALL be absent and write_en_out SHALL be all ones in ESCREVE.

Verification
REQ-029 Reset, then lvv_write_en_in=8'h01 with addr slice 0 = 0x10 per port -> next cycle write_en_out=8'hFF, write_addr_out ports = 0x10, ready_out=8'h01, busy_out=1; the following cycle all zero.
REQ-030 lvv_write_en_in=8'h81 held, each requester dropping after its ready -> ready_out sequence 8'h01, then 8'h80, two cycles apart.
REQ-031 All 8 requesters held high with retry -> grants 0,1,...,7,0, with one grant every 2 cycles and no index starved.
REQ-032 rst pulsed during ESCREVE for requester 3 -> outputs zero next cycle; requester 3 still high is granted first after reset because ultimo=7.
REQ-033 With GERENCIADOR_ESCRITAS_MASK_EN, requester 2 mask=8'h05 -> write_en_out=8'h05 and ready_out=8'h04; with mask=8'h00 -> write_en_out=0 and ready_out=8'h04.
